// File: rtl/adc_trigger_unit_pkg.sv
// Shared definitions for the ADC trigger unit: default widths and FSM states.
package adc_trigger_unit_pkg;

    localparam int unsigned ADC_BITS_DEF = 12;
    localparam int unsigned CNT_BITS_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INACT,
        ARMED,
        DELAY,
        FIRE,
        DONE
    } state_e;

endpackage

// File: rtl/adc_trigger_unit_if.sv
// Control/status bundle between the capture controller and the trigger unit.
interface adc_trigger_unit_if #(
    parameter int unsigned pADC_BITS = adc_trigger_unit_pkg::ADC_BITS_DEF,
    parameter int unsigned pCNT_BITS = adc_trigger_unit_pkg::CNT_BITS_DEF
);
    logic                 cmd_arm_adc;
    logic                 trigger_mode;
    logic                 trigger_wait;
    logic                 trigger_now;
    logic                 trigger_src_adc;
    logic [pCNT_BITS-1:0] trigger_offset;
    logic [pADC_BITS-1:0] trigger_adclevel;
    logic [pADC_BITS-1:0] adc_data;
    logic                 trig_i;
    logic                 capture_go;
    logic                 armed_and_ready;
    logic [pCNT_BITS-1:0] trigger_length;

    modport master (
        output cmd_arm_adc, trigger_mode, trigger_wait, trigger_now, trigger_src_adc,
               trigger_offset, trigger_adclevel, adc_data, trig_i,
        input  capture_go, armed_and_ready, trigger_length
    );

    modport slave (
        input  cmd_arm_adc, trigger_mode, trigger_wait, trigger_now, trigger_src_adc,
               trigger_offset, trigger_adclevel, adc_data, trig_i,
        output capture_go, armed_and_ready, trigger_length
    );
endinterface

// File: rtl/trigger_source_detect.sv
// Selects the trigger source, registers it twice and derives the polarity-adjusted
// active level and its rising edge (event), both presented registered.
module trigger_source_detect
    import adc_trigger_unit_pkg::*;
#(
    parameter int unsigned pADC_BITS = ADC_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trigger_src_adc,
    input  logic                 trigger_mode,
    input  logic [pADC_BITS-1:0] adc_data,
    input  logic [pADC_BITS-1:0] trigger_adclevel,
    input  logic                 trig_i,
    output logic                 active,
    output logic                 trig_event
);

    logic trig_r_q,   trig_r_d;
    logic trig_r2_q,  trig_r2_d;
    logic active_q,   active_d;
    logic event_q,    event_d;
    logic raw_c, prev_c;

    always_comb begin
        raw_c     = trigger_src_adc ? (adc_data >= trigger_adclevel) : trig_i;
        trig_r_d  = raw_c;
        trig_r2_d = trig_r_q;
        active_d  = trigger_mode ? trig_r_q  : ~trig_r_q;
        prev_c    = trigger_mode ? trig_r2_q : ~trig_r2_q;
        event_d   = active_d & ~prev_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_r_q  <= 1'b0;
            trig_r2_q <= 1'b0;
            active_q  <= 1'b0;
            event_q   <= 1'b0;
        end else begin
            trig_r_q  <= trig_r_d;
            trig_r2_q <= trig_r2_d;
            active_q  <= active_d;
            event_q   <= event_d;
        end
    end

    assign active     = active_q;
    assign trig_event = event_q;

endmodule

// File: rtl/adc_trigger_unit.sv
// ADC capture trigger: arm/wait/fire sequencing with programmable post-trigger
// delay, plus measurement of the most recent trigger-active duration.
module adc_trigger_unit
    import adc_trigger_unit_pkg::*;
#(
    parameter int unsigned pADC_BITS = ADC_BITS_DEF,
    parameter int unsigned pCNT_BITS = CNT_BITS_DEF
) (
    input  logic              adc_sampleclk,
    input  logic              reset_n,
    adc_trigger_unit_if.slave bus
);

    state_e               state_q, state_d;
    logic [pCNT_BITS-1:0] dly_cnt_q, dly_cnt_d;
    logic [pCNT_BITS-1:0] offset_q, offset_d;
    logic [pCNT_BITS-1:0] len_cnt_q, len_cnt_d;
    logic [pCNT_BITS-1:0] trig_len_q, trig_len_d;
    logic                 capture_go_q, capture_go_d;
    logic                 ready_q, ready_d;
    logic                 arm_ok_q, arm_ok_d;
    logic                 active_prev_q;
    logic                 active, trig_event;
    logic                 fire_c, leave_armed_c;

    trigger_source_detect #(
        .pADC_BITS (pADC_BITS)
    ) u_detect (
        .clk              (adc_sampleclk),
        .rst_n            (reset_n),
        .trigger_src_adc  (bus.trigger_src_adc),
        .trigger_mode     (bus.trigger_mode),
        .adc_data         (bus.adc_data),
        .trigger_adclevel (bus.trigger_adclevel),
        .trig_i           (bus.trig_i),
        .active           (active),
        .trig_event       (trig_event)
    );

    // Arming needs cmd_arm_adc seen low since reset, so a reset cannot re-arm by itself.
    always_comb begin
        state_d       = state_q;
        dly_cnt_d     = dly_cnt_q;
        offset_d      = offset_q;
        arm_ok_d      = arm_ok_q | ~bus.cmd_arm_adc;
        leave_armed_c = 1'b0;
        fire_c        = trig_event | bus.trigger_now;

        if (!bus.cmd_arm_adc) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:       if (arm_ok_q) state_d = bus.trigger_wait ? WAIT_INACT : ARMED;
                WAIT_INACT: if (!active) state_d = ARMED;
                ARMED: begin
                    if (fire_c) begin
                        leave_armed_c = 1'b1;
                        offset_d      = bus.trigger_offset;
                        dly_cnt_d     = '0;
                        state_d       = (bus.trigger_offset == '0) ? FIRE : DELAY;
                    end
                end
                DELAY: begin
                    dly_cnt_d = dly_cnt_q + pCNT_BITS'(1);
                    if (dly_cnt_q == offset_q - pCNT_BITS'(1)) state_d = FIRE;
                end
                FIRE:    state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end

        capture_go_d = (state_d == FIRE);
        ready_d      = (state_d == ARMED);
    end

    // Active-period length; a forced trigger while inactive reports a zero length.
    always_comb begin
        len_cnt_d  = len_cnt_q;
        trig_len_d = trig_len_q;
        if (active_prev_q && !active) trig_len_d = len_cnt_q;
        if (leave_armed_c && bus.trigger_now && !active) trig_len_d = '0;
        if (leave_armed_c) begin
            len_cnt_d = pCNT_BITS'(active);
        end else if (active && (len_cnt_q != '1)) begin
            len_cnt_d = len_cnt_q + pCNT_BITS'(1);
        end
    end

    always_ff @(posedge adc_sampleclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            dly_cnt_q     <= '0;
            offset_q      <= '0;
            len_cnt_q     <= '0;
            trig_len_q    <= '0;
            capture_go_q  <= 1'b0;
            ready_q       <= 1'b0;
            arm_ok_q      <= 1'b0;
            active_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dly_cnt_q     <= dly_cnt_d;
            offset_q      <= offset_d;
            len_cnt_q     <= len_cnt_d;
            trig_len_q    <= trig_len_d;
            capture_go_q  <= capture_go_d;
            ready_q       <= ready_d;
            arm_ok_q      <= arm_ok_d;
            active_prev_q <= active;
        end
    end

    assign bus.capture_go      = capture_go_q;
    assign bus.armed_and_ready = ready_q;
    assign bus.trigger_length  = trig_len_q;

endmodule

// File: tb/tb_adc_trigger_unit.sv
// Directed bench for adc_trigger_unit: an event-scheduling reference model checked
// every cycle, plus hand-computed latency/length expectations per scenario.
module tb_adc_trigger_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    adc_trigger_unit_if bus_if ();

    adc_trigger_unit dut (
        .adc_sampleclk (clk),
        .reset_n       (rst_n),
        .bus           (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: trigger level seen two edges late, capture scheduled at
    // (edge the trigger is honoured) + offset, one capture per arm.
    bit          m_r0 = 0, m_r1 = 0, m_act = 0, m_act_d = 0, m_ev = 0;
    bit          m_arm_ok = 0, m_wait = 0, m_armed = 0, m_pend = 0, m_spent = 0;
    bit          m_exit, m_raw, m_anew;
    int          m_edge = 0, m_fire_at = 0;
    logic [31:0] m_len = 0;
    bit          e_go = 0, e_rdy = 0;
    logic [31:0] e_len = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r0 = 0; m_r1 = 0; m_act = 0; m_act_d = 0; m_ev = 0;
            m_arm_ok = 0; m_wait = 0; m_armed = 0; m_pend = 0; m_spent = 0;
            m_len = 0; e_len = 0; e_go = 0; e_rdy = 0;
        end else begin
            m_edge++;
            e_go   = 0;
            m_exit = 0;
            if (!bus_if.cmd_arm_adc) begin
                m_arm_ok = 1; m_wait = 0; m_armed = 0; m_pend = 0; m_spent = 0;
            end else if (m_spent) begin
                m_spent = 1;
            end else if (m_pend) begin
                if (m_edge == m_fire_at) begin e_go = 1; m_pend = 0; m_spent = 1; end
            end else if (m_armed) begin
                if (m_ev || bus_if.trigger_now) begin
                    m_armed = 0;
                    m_exit  = 1;
                    if (bus_if.trigger_offset == 0) begin e_go = 1; m_spent = 1; end
                    else begin m_pend = 1; m_fire_at = m_edge + int'(bus_if.trigger_offset); end
                end
            end else if (m_wait) begin
                if (!m_act) begin m_wait = 0; m_armed = 1; end
            end else if (m_arm_ok) begin
                if (bus_if.trigger_wait) m_wait = 1; else m_armed = 1;
            end
            e_rdy = m_armed;

            if (m_act_d && !m_act) e_len = m_len;
            if (m_exit && bus_if.trigger_now && !m_act) e_len = 0;
            if (m_exit) m_len = m_act ? 32'd1 : 32'd0;
            else if (m_act && m_len != 32'hFFFF_FFFF) m_len = m_len + 1;

            m_raw   = bus_if.trigger_src_adc ? (bus_if.adc_data >= bus_if.trigger_adclevel)
                                             : bus_if.trig_i;
            m_anew  = bus_if.trigger_mode ? m_r0 : !m_r0;
            m_ev    = m_anew && !(bus_if.trigger_mode ? m_r1 : !m_r1);
            m_act_d = m_act;
            m_act   = m_anew;
            m_r1    = m_r0;
            m_r0    = m_raw;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("model_capture_go", 32'(bus_if.capture_go), 32'(e_go));
            chk("model_armed_rdy",  32'(bus_if.armed_and_ready), 32'(e_rdy));
            chk("model_length",     bus_if.trigger_length, e_len);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Cycle index (relative to the last drive edge) of the first high sample, and count.
    task automatic watch(input int sel, input int n, output int first, output int cnt);
        logic v;
        first = -1;
        cnt   = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            v = (sel == 0) ? bus_if.capture_go : bus_if.armed_and_ready;
            if (v) begin cnt++; if (first < 0) first = i; end
        end
    endtask

    int first, cnt;

    initial begin
        bus_if.cmd_arm_adc      = 1'b0;
        bus_if.trigger_mode     = 1'b1;
        bus_if.trigger_wait     = 1'b0;
        bus_if.trigger_now      = 1'b0;
        bus_if.trigger_src_adc  = 1'b0;
        bus_if.trigger_offset   = 32'd0;
        bus_if.trigger_adclevel = 12'h800;
        bus_if.adc_data         = 12'h000;
        bus_if.trig_i           = 1'b0;

        tick(3);
        chk("reset_go",  32'(bus_if.capture_go), 32'd0);
        chk("reset_rdy", 32'(bus_if.armed_and_ready), 32'd0);
        chk("reset_len", bus_if.trigger_length, 32'd0);
        rst_n = 1'b1;
        tick(3);

        // Digital rising edge, zero offset: capture 3 cycles after the edge, length 6
        bus_if.cmd_arm_adc = 1'b1;
        tick(3);
        chk("s1_ready", 32'(bus_if.armed_and_ready), 32'd1);
        bus_if.trig_i = 1'b1;
        watch(0, 6, first, cnt);
        chk("s1_go_cycle", 32'(first), 32'd3);
        chk("s1_go_count", 32'(cnt), 32'd1);
        bus_if.trig_i = 1'b0;
        tick(5);
        chk("s1_length", bus_if.trigger_length, 32'd6);
        bus_if.cmd_arm_adc = 1'b0;
        tick(2);

        // ADC threshold crossing 0x7FF -> 0x800 with offset 5, held 12 cycles
        bus_if.trigger_src_adc = 1'b1;
        bus_if.trigger_offset  = 32'd5;
        bus_if.adc_data        = 12'h7FF;
        bus_if.cmd_arm_adc     = 1'b1;
        tick(3);
        bus_if.adc_data = 12'h800;
        watch(0, 10, first, cnt);
        chk("s2_go_cycle", 32'(first), 32'd8);
        chk("s2_go_count", 32'(cnt), 32'd1);
        tick(2);
        bus_if.adc_data = 12'h7FF;
        tick(5);
        chk("s2_length", bus_if.trigger_length, 32'd12);
        bus_if.cmd_arm_adc     = 1'b0;
        bus_if.trigger_src_adc = 1'b0;
        bus_if.trigger_offset  = 32'd0;
        tick(2);

        // trigger_wait with trigger already high at arm
        bus_if.trigger_wait = 1'b1;
        bus_if.trig_i       = 1'b1;
        tick(4);
        bus_if.cmd_arm_adc = 1'b1;
        watch(0, 6, first, cnt);
        chk("s3_no_go_while_high", 32'(cnt), 32'd0);
        chk("s3_not_ready", 32'(bus_if.armed_and_ready), 32'd0);
        bus_if.trig_i = 1'b0;
        watch(1, 6, first, cnt);
        chk("s3_ready_cycle", 32'(first), 32'd3);
        bus_if.trig_i = 1'b1;
        watch(0, 6, first, cnt);
        chk("s3_go_cycle", 32'(first), 32'd3);
        chk("s3_go_count", 32'(cnt), 32'd1);
        bus_if.trig_i       = 1'b0;
        bus_if.cmd_arm_adc  = 1'b0;
        bus_if.trigger_wait = 1'b0;
        tick(3);

        // Forced trigger into a long delay, then disarm half way through
        bus_if.trigger_offset = 32'd100;
        bus_if.cmd_arm_adc    = 1'b1;
        tick(3);
        chk("s4_ready", 32'(bus_if.armed_and_ready), 32'd1);
        bus_if.trigger_now = 1'b1;
        tick(1);
        bus_if.trigger_now = 1'b0;
        chk("s4_len_zero", bus_if.trigger_length, 32'd0);
        chk("s4_ready_off", 32'(bus_if.armed_and_ready), 32'd0);
        tick(49);
        bus_if.cmd_arm_adc = 1'b0;
        watch(0, 120, first, cnt);
        chk("s4_abandoned", 32'(cnt), 32'd0);

        // trigger_now coincident with a rising edge, then a second edge before disarm
        bus_if.trigger_offset = 32'd0;
        bus_if.cmd_arm_adc    = 1'b1;
        tick(3);
        bus_if.trig_i      = 1'b1;
        bus_if.trigger_now = 1'b1;
        watch(0, 1, first, cnt);
        chk("s5_go_cycle", 32'(first), 32'd1);
        bus_if.trigger_now = 1'b0;
        watch(0, 6, first, cnt);
        chk("s5_single_go", 32'(cnt), 32'd0);
        bus_if.trig_i = 1'b0;
        tick(3);
        bus_if.trig_i = 1'b1;
        watch(0, 6, first, cnt);
        chk("s5_second_edge", 32'(cnt), 32'd0);
        bus_if.trig_i      = 1'b0;
        bus_if.cmd_arm_adc = 1'b0;
        tick(3);

        // Reset pulse during a pending delay, released while still armed and triggered
        bus_if.trigger_offset = 32'd20;
        bus_if.cmd_arm_adc    = 1'b1;
        tick(3);
        bus_if.trig_i = 1'b1;
        tick(6);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_go",  32'(bus_if.capture_go), 32'd0);
        chk("s6_rst_rdy", 32'(bus_if.armed_and_ready), 32'd0);
        chk("s6_rst_len", bus_if.trigger_length, 32'd0);
        tick(2);
        rst_n = 1'b1;
        watch(0, 30, first, cnt);
        chk("s6_no_go_after_rst", 32'(cnt), 32'd0);
        chk("s6_not_ready", 32'(bus_if.armed_and_ready), 32'd0);
        bus_if.cmd_arm_adc = 1'b0;
        tick(1);
        bus_if.cmd_arm_adc = 1'b1;
        tick(3);
        chk("s6_rearm_ready", 32'(bus_if.armed_and_ready), 32'd1);
        bus_if.cmd_arm_adc    = 1'b0;
        bus_if.trigger_offset = 32'd0;
        tick(3);

        // Falling-edge mode: trigger on trig_i 1 -> 0, low for 6 cycles
        bus_if.trig_i       = 1'b1;
        bus_if.trigger_mode = 1'b0;
        tick(4);
        bus_if.cmd_arm_adc = 1'b1;
        tick(3);
        chk("s7_ready", 32'(bus_if.armed_and_ready), 32'd1);
        bus_if.trig_i = 1'b0;
        watch(0, 6, first, cnt);
        chk("s7_go_cycle", 32'(first), 32'd3);
        chk("s7_go_count", 32'(cnt), 32'd1);
        bus_if.trig_i = 1'b1;
        tick(5);
        chk("s7_length", bus_if.trigger_length, 32'd6);
        bus_if.cmd_arm_adc = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
